// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types, constants and helpers for the data-memory access path.
//   ldst_e        : load/store opcode carried on req_ldst / mem_ldst (3 bits)
//   mau_state_e   : mem_access_unit FSM states
//   MMIO_BASE     : start of the switch/LED window. It needs no special path
//                   and is kept here for address-map reference.
//   is_store      : opcode is sb/sh/sw
//   is_misaligned : half access on an odd address, or word access not on a
//                   4-byte boundary
//   align_lo      : forces address bits [1:0] to the natural alignment of the op
//   store_lanes   : replicates store data across the byte lanes of the word
// Optional feature macro used by the unit: MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } ldst_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

  function automatic logic is_store(input ldst_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_misaligned(input ldst_e op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: return lo[0];
      LW, SW:      return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input ldst_e op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: return {lo[1], 1'b0};
      LW, SW:      return 2'b00;
      default:     return lo;
    endcase
  endfunction

  // The memory picks the active lane(s) from addr; replicating the data means
  // whichever lane it selects already holds the right bytes.
  function automatic logic [31:0] store_lanes(input ldst_e op, input logic [31:0] wdata);
    case (op)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load data formatter. Picks the addressed byte/half out of the
// raw aligned memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_word    in  32  raw aligned word from memory
//   i_ldst    in  3   opcode (ldst_e encoding)
//   i_addr_lo in  2   byte address bits [1:0]
//   o_data    out 32  extended load data; 0 for store opcodes
// -----------------------------------------------------------------------------
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_ldst,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (ldst_e'(i_ldst))
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LW:      o_data = i_word;
      LBU:     o_data = {24'd0, w_byte};
      LHU:     o_data = {16'd0, w_half};
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// CPU-side initiator for the data-memory port b. Accepts one load/store from
// the MEM stage, drives the memory for one cycle, waits out READ_LAT and
// returns the extended load data with a one-cycle resp_valid pulse.
// MMIO addresses (MMIO_BASE and up) go through the same path unchanged.
// Parameters:
//   READ_LAT  memory cycles from address to valid mem_rdata (1..3)
//   AW        address width (>= 2)
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_ldst/addr/wdata       request opcode, byte address, LSB-justified data
//   resp_valid/resp_rdata     completion pulse and extended load data
//   resp_err                  misaligned access flag (MISALIGN_TRAP_EN only)
//   mem_ldst/addr/wdata/we    memory port b controls
//   mem_rdata                 raw aligned word from memory
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with resp_err instead of silently aligning the address.
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_ldst,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic          resp_err,
`endif
  output logic [2:0]    mem_ldst,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  // WAIT lasts READ_LAT-1 cycles; the counter is loaded with READ_LAT-2 and
  // the last WAIT cycle is the one that sees zero.
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  mau_state_e    r_state;
  logic [1:0]    r_cnt;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic [2:0]    r_mem_ldst;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_mem_we;
`ifdef MISALIGN_TRAP_EN
  logic          r_resp_err;
  logic          w_misaligned;
`endif

  logic          w_accept;
  ldst_e         w_op;
  logic [AW-1:0] w_addr_aligned;
  logic [31:0]   w_ext;

  assign w_accept       = req_valid && r_req_ready;
  assign w_op           = ldst_e'(req_ldst);
  assign w_addr_aligned = {req_addr[AW-1:2], align_lo(w_op, req_addr[1:0])};
`ifdef MISALIGN_TRAP_EN
  assign w_misaligned   = is_misaligned(w_op, req_addr[1:0]);
`endif

  // The latched mem_* registers double as the request latches, so extraction
  // works from the op and address the memory actually saw.
  load_extend u_load_extend (
    .i_word    (mem_rdata),
    .i_ldst    (r_mem_ldst),
    .i_addr_lo (r_mem_addr[1:0]),
    .o_data    (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_ldst   <= 3'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_mem_we     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            // Trapped accesses never touch the memory port.
            if (w_misaligned) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else
`endif
            begin
              r_state     <= ISSUE;
              r_mem_ldst  <= req_ldst;
              r_mem_addr  <= w_addr_aligned;
              r_mem_wdata <= store_lanes(w_op, req_wdata);
              r_mem_we    <= is_store(w_op);
            end
          end
        end
        ISSUE: begin
          r_mem_we <= 1'b0;
          r_cnt    <= WAIT_INIT;
          if (is_store(ldst_e'(r_mem_ldst))) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'd0;
          end else if (READ_LAT == 1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ext;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          r_resp_err   <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mem_ldst   = r_mem_ldst;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
`ifdef MISALIGN_TRAP_EN
  assign resp_err   = r_resp_err;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int READ_LAT = 3;
  localparam int AW       = 32;
  localparam int LD_LAT   = READ_LAT + 1;
  localparam int ST_LAT   = 2;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_ldst;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic          resp_err;
`endif
  logic [2:0]    mem_ldst;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  mem_access_unit #(.READ_LAT(READ_LAT), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ldst   (req_ldst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
`ifdef MISALIGN_TRAP_EN
    .resp_err   (resp_err),
`endif
    .mem_ldst   (mem_ldst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-lane writes selected by ldst/addr, word reads held
  // stable while the address is held.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_ldst)
        3'd5: mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[8*mem_addr[1:0] +: 8];
        3'd6: mem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[16*mem_addr[1] +: 16];
        3'd7: mem[mem_addr[7:2]] <= mem_wdata;
        default: ;
      endcase
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_ldst;
  int          we_cnt;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(req_ready,  1'b1,  {tag, "_req_ready"});
    chk(resp_valid, 1'b0,  {tag, "_resp_valid"});
    chk(resp_rdata, 32'd0, {tag, "_resp_rdata"});
`ifdef MISALIGN_TRAP_EN
    chk(resp_err,   1'b0,  {tag, "_resp_err"});
`endif
    chk(mem_we,     1'b0,  {tag, "_mem_we"});
    chk(mem_ldst,   3'd0,  {tag, "_mem_ldst"});
    chk(mem_addr,   32'd0, {tag, "_mem_addr"});
    chk(mem_wdata,  32'd0, {tag, "_mem_wdata"});
  endtask

  // Called and returns at a negative clock edge. With hold=1 the request stays
  // asserted after acceptance, so the unit sees a second, identical request.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input bit hold,
                         input string tag);
    exp_t e;
    int   n;
    int   lat;
    bit   got;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.tag   = tag;
    sb_q.push_back(e);
    req_valid = 1'b1;
    req_ldst  = op;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk(1'b0, 1'b1, {tag, "_accept_timeout"});
      req_valid = 1'b0;
      sb_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    lat    = 0;
    we_cnt = 0;
    got    = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_ldst  = mem_ldst;
      end
      if (mem_we === 1'b1) we_cnt++;
      chk(req_ready, 1'b0, {tag, "_ready_low"});
      if (resp_valid === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk(1'b0, 1'b1, {tag, "_resp_timeout"});
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    chk(resp_rdata, e.rdata, {e.tag, "_rdata"});
    chk(lat, e.lat, {e.tag, "_latency"});
`ifdef MISALIGN_TRAP_EN
    chk(resp_err, e.err, {e.tag, "_err"});
`endif
    chk(we_cnt, ((op >= OP_SB) && !exp_err) ? 1 : 0, {tag, "_we_cycles"});
    @(negedge clk);
    chk(resp_valid, 1'b0, {tag, "_valid_pulse"});
    chk(req_ready,  1'b1, {tag, "_ready_back"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ldst  = 3'd0;
    req_addr  = '0;
    req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store
    run_req(OP_SW, 32'd100, 32'h1234_56F8, 32'd0, 1'b0, ST_LAT, 1'b0, "t1_sw");
    chk(cap_wdata, 32'h1234_56F8, "t1_mem_wdata");
    chk(cap_ldst,  OP_SW,         "t1_mem_ldst");
    chk(cap_addr,  32'd100,       "t1_mem_addr");

    // 2: extraction and extension
    run_req(OP_LH,  32'd102, 32'd0, 32'h0000_1234, 1'b0, LD_LAT, 1'b0, "t2_lh102");
    run_req(OP_LB,  32'd100, 32'd0, 32'hFFFF_FFF8, 1'b0, LD_LAT, 1'b0, "t2_lb100");
    run_req(OP_LBU, 32'd100, 32'd0, 32'h0000_00F8, 1'b0, LD_LAT, 1'b0, "t2_lbu100");
    run_req(OP_LB,  32'd103, 32'd0, 32'h0000_0012, 1'b0, LD_LAT, 1'b0, "t2_lb103");
    run_req(OP_LHU, 32'd100, 32'd0, 32'h0000_56F8, 1'b0, LD_LAT, 1'b0, "t2_lhu100");

    // 3: sub-word stores with lane replication
    run_req(OP_SB, 32'd101, 32'hFFFF_FFAB, 32'd0, 1'b0, ST_LAT, 1'b0, "t3_sb101");
    chk(cap_wdata, 32'hABAB_ABAB, "t3_sb_wdata");
    chk(cap_ldst,  OP_SB,         "t3_sb_ldst");
    run_req(OP_LW, 32'd100, 32'd0, 32'h1234_ABF8, 1'b0, LD_LAT, 1'b0, "t3_lw_after_sb");
    run_req(OP_SH, 32'd102, 32'h0000_CAFE, 32'd0, 1'b0, ST_LAT, 1'b0, "t3_sh102");
    chk(cap_wdata, 32'hCAFE_CAFE, "t3_sh_wdata");
    run_req(OP_LH, 32'd102, 32'd0, 32'hFFFF_CAFE, 1'b0, LD_LAT, 1'b0, "t3_lh_after_sh");

    // 4: READ_LAT=3 word load with a second request held pending
    run_req(OP_LW, 32'd100, 32'd0, 32'hCAFE_ABF8, 1'b0, LD_LAT, 1'b1, "t4_lw_held");
    run_req(OP_LW, 32'd100, 32'd0, 32'hCAFE_ABF8, 1'b0, LD_LAT, 1'b0, "t4_lw_second");

    // 5: MMIO store, then asynchronous reset mid-access
    run_req(OP_SW, 32'hFFFF_FF04, 32'd5, 32'd0, 1'b0, ST_LAT, 1'b0, "t5_mmio_sw");
    chk(cap_addr, 32'hFFFF_FF04, "t5_mmio_addr");

    req_valid = 1'b1; req_ldst = OP_SW; req_addr = 32'h8; req_wdata = 32'h77;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk(mem_we, 1'b1, "t5_we_before_rst");
    rst_n = 1'b0;
    #1;
    chk(mem_we, 1'b0, "t5_we_async_drop");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    req_valid = 1'b1; req_ldst = OP_LW; req_addr = 32'hFFFF_FF04; req_wdata = 32'd0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk(mem_addr, 32'hFFFF_FF04, "t5_ld_issue_addr");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("t5_rst_in_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(OP_LW, 32'hFFFF_FF04, 32'd0, 32'd5, 1'b0, LD_LAT, 1'b0, "t5_mmio_lw");

    // 6: misaligned word load
`ifdef MISALIGN_TRAP_EN
    run_req(OP_LW, 32'h66, 32'd0, 32'd0, 1'b1, 1, 1'b0, "t6_lw_trap");
    run_req(OP_SH, 32'h67, 32'h1111, 32'd0, 1'b1, 1, 1'b0, "t6_sh_trap");
    run_req(OP_LW, 32'd100, 32'd0, 32'hCAFE_ABF8, 1'b0, LD_LAT, 1'b0, "t6_lw_after_trap");
`else
    run_req(OP_LW, 32'h66, 32'd0, 32'hCAFE_ABF8, 1'b0, LD_LAT, 1'b0, "t6_lw_align");
    chk(cap_addr, 32'h64, "t6_mem_addr_aligned");
`endif

    chk(sb_q.size(), 0, "scoreboard_empty");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
